// File: rtl/uart_imem_loader.sv
// uart_imem_loader: receives 8N1 UART load frames and writes 32-bit words into instruction memory
module uart_imem_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADRS_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rxd,
   output logic              imem_we,
   output logic [ADRS_W-1:0] imem_adrs,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              frame_err
);
   localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {LD_SYNC, LD_CNT_HI, LD_CNT_LO, LD_DATA, LD_DONE} ld_state_t;
   logic              sync1_q, sync2_q;
   rx_state_t         rx_q, rx_d;
   logic [15:0]       tick_q, tick_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        rsh_q, rsh_d;
   logic              bv_q, bv_d, be_q, be_d;
   ld_state_t         ld_q, ld_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADRS_W-1:0] ptr_q, ptr_d, wadrs_q, wadrs_d;
   logic [23:0]       wsh_q, wsh_d;
   logic [1:0]        bi_q, bi_d;
   logic              we_q, we_d, err_q, err_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              in_load;
   // Receiver state and the two-flop rxd synchronizer
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         rx_q    <= RX_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         rsh_q   <= '0;
         bv_q    <= 1'b0;
         be_q    <= 1'b0;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         rx_q    <= rx_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         rsh_q   <= rsh_d;
         bv_q    <= bv_d;
         be_q    <= be_d;
      end
   end
   // Receiver next state: start-bit qualification at half bit, then one sample per bit period
   always_comb begin
      rx_d   = rx_q;
      tick_d = tick_q + 16'd1;
      bit_d  = bit_q;
      rsh_d  = rsh_q;
      bv_d   = 1'b0;
      be_d   = 1'b0;
      case (rx_q)
         RX_IDLE: begin
            tick_d = '0;
            if (!sync2_q) begin
               rx_d  = RX_START;
               bit_d = '0;
            end
         end
         RX_START: if (tick_q == HALF) begin
            tick_d = '0;
            if (sync2_q) rx_d = RX_IDLE;
            else rx_d = RX_BITS;
         end
         RX_BITS: if (tick_q == FULL) begin
            tick_d = '0;
            rsh_d  = {sync2_q, rsh_q[7:1]};
            bit_d  = bit_q + 3'd1;
            if (bit_q == 3'd7) rx_d = RX_STOP;
         end
         RX_STOP: if (tick_q == FULL) begin
            tick_d = '0;
            rx_d   = RX_IDLE;
            bv_d   = sync2_q;
            be_d   = !sync2_q;
         end
         default: rx_d = RX_IDLE;
      endcase
   end
   // Loader state, write port registers and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_q    <= LD_SYNC;
         cnt_q   <= '0;
         ptr_q   <= '0;
         wsh_q   <= '0;
         bi_q    <= '0;
         we_q    <= 1'b0;
         wadrs_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         ld_q    <= ld_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         wsh_q   <= wsh_d;
         bi_q    <= bi_d;
         we_q    <= we_d;
         wadrs_q <= wadrs_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end
   // Loader next state; DATA lingers one cycle with a zero count so hold drops after the last strobe
   always_comb begin
      ld_d      = ld_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      wsh_d     = wsh_q;
      bi_d      = bi_q;
      we_d      = 1'b0;
      wadrs_d   = wadrs_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      in_load   = ld_q inside {LD_CNT_HI, LD_CNT_LO, LD_DATA};
      cpu_hold  = in_load;
      load_done = ld_q == LD_DONE;
      if (in_load && be_q) begin
         ld_d  = LD_SYNC;
         err_d = 1'b1;
      end else begin
         case (ld_q)
            LD_SYNC, LD_DONE: if (bv_q && rsh_q == 8'h55) begin
               ld_d  = LD_CNT_HI;
               err_d = 1'b0;
               ptr_d = '0;
            end
            LD_CNT_HI: if (bv_q) begin
               cnt_d = {rsh_q, 8'h00};
               ld_d  = LD_CNT_LO;
            end
            LD_CNT_LO: if (bv_q) begin
               cnt_d = {cnt_q[15:8], rsh_q};
               bi_d  = '0;
               if (cnt_q[15:8] == 8'h00 && rsh_q == 8'h00) ld_d = LD_DONE;
               else ld_d = LD_DATA;
            end
            LD_DATA: if (cnt_q == 16'd0) ld_d = LD_DONE;
            else if (bv_q) begin
               wsh_d = {wsh_q[15:0], rsh_q};
               bi_d  = bi_q + 2'd1;
               if (bi_q == 2'd3) begin
                  we_d    = 1'b1;
                  wadrs_d = ptr_q;
                  wdata_d = {wsh_q, rsh_q};
                  ptr_d   = ptr_q + ADRS_W'(1);
                  cnt_d   = cnt_q - 16'd1;
               end
            end
            default: ld_d = LD_SYNC;
         endcase
      end
   end
   assign imem_we    = we_q;
   assign imem_adrs  = wadrs_q;
   assign imem_wdata = wdata_q;
   assign frame_err  = err_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: drives UART load frames and checks writes and status against a memory model
module tb_uart_imem_loader;
   typedef struct packed {logic [3:0] a; logic [31:0] d;} wr_t;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rxd = 1'b1;
   logic        imem_we, cpu_hold, load_done, frame_err;
   logic [3:0]  imem_adrs;
   logic [31:0] imem_wdata;
   int          checks = 0;
   int          fails = 0;
   int          cyc = 0, last_we_cyc = 0, fall_cyc = 0, done_rise_cyc = 0;
   bit          hold_prev = 0, done_prev = 0, hold_seen = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [31:0] words_q[$];
   logic [31:0] model_mem[16];
   logic [31:0] dut_mem[16];

   uart_imem_loader #(.CLKS_PER_BIT(4), .ADRS_W(4)) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .imem_we(imem_we), .imem_adrs(imem_adrs),
      .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Write monitor: every strobe must match the next expected write, in order
   always @(negedge clk) begin
      cyc++;
      if (imem_we) begin
         last_we_cyc = cyc;
         dut_mem[imem_adrs] = imem_wdata;
         if (exp_q.size() == 0) chk("we_spurious", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk("we_adrs", imem_adrs, mon_e.a);
            chk("we_data", imem_wdata, mon_e.d);
         end
      end
      if (cpu_hold && !hold_prev) hold_seen = 1;
      if (!cpu_hold && hold_prev) fall_cyc = cyc;
      if (load_done && !done_prev) done_rise_cyc = cyc;
      hold_prev = cpu_hold;
      done_prev = load_done;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      rxd = 1'b0;
      idle(4);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(4);
      end
      rxd = stop;
      idle(4);
      rxd = 1'b1;
   endtask

   task automatic load(input int n, input bit gaps);
      logic [15:0] nn;
      nn = 16'(n);
      hold_seen = 0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({4'(i), words_q[i]});
         model_mem[i % 16] = words_q[i];
      end
      send_byte(8'h55);
      send_byte(nn[15:8]);
      send_byte(nn[7:0]);
      for (int i = 0; i < n; i++)
         for (int k = 3; k >= 0; k--) begin
            send_byte(words_q[i][8*k +: 8]);
            if (gaps) idle($urandom_range(0, 3));
         end
      idle(20);
      chk("hold_end", cpu_hold, 0);
      chk("done_end", load_done, 1);
      chk("err_end", frame_err, 0);
      chk("hold_seen", hold_seen, 1);
      chk("writes_left", exp_q.size(), 0);
      if (n > 0) begin
         chk("hold_fall_t", fall_cyc, last_we_cyc + 1);
         chk("done_rise_t", done_rise_cyc, fall_cyc);
      end
   endtask

   task automatic cmp_mem();
      for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), dut_mem[i], model_mem[i]);
   endtask

   initial begin
      logic nz;
      logic [7:0] junk;
      int n;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = '0;
         dut_mem[i] = '0;
      end
      idle(3);
      chk("rst_we", imem_we, 0);
      chk("rst_adrs", imem_adrs, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_done", load_done, 0);
      chk("rst_err", frame_err, 0);
      reset = 1'b0;
      nz = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         nz = nz | imem_we | cpu_hold | load_done | frame_err | (|imem_adrs) | (|imem_wdata);
      end
      chk("idle_quiet", nz, 0);
      words_q = {32'hDEADBEEF, 32'h12345678};
      load(2, 0);
      words_q = {};
      load(0, 0);
      hold_seen = 0;
      send_byte(8'h55);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'h11, 1'b0);
      idle(20);
      chk("ferr_set", frame_err, 1);
      chk("ferr_hold", cpu_hold, 0);
      chk("ferr_done", load_done, 0);
      chk("ferr_nowrite", exp_q.size(), 0);
      send_byte(8'h55, 1'b0);
      idle(20);
      chk("sync_err_keep", frame_err, 1);
      chk("sync_err_nohold", cpu_hold, 0);
      send_byte(8'h55);
      idle(10);
      chk("ferr_clear", frame_err, 0);
      chk("ferr_rehold", cpu_hold, 1);
      send_byte(8'h00);
      send_byte(8'h00);
      idle(20);
      chk("ferr_redone", load_done, 1);
      words_q = {};
      for (int i = 0; i < 17; i++) words_q.push_back(32'(i));
      load(17, 0);
      chk("wrap_adrs0", dut_mem[0], 32'h00000010);
      cmp_mem();
      hold_seen = 0;
      exp_q.push_back({4'd0, 32'hA5A50F0F});
      model_mem[0] = 32'hA5A50F0F;
      send_byte(8'h55);
      idle(3);
      rxd = 1'b0;
      @(negedge clk);
      rxd = 1'b1;
      idle(10);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hA5);
      send_byte(8'hA5);
      send_byte(8'h0F);
      send_byte(8'h0F);
      idle(20);
      chk("glitch_writes", exp_q.size(), 0);
      chk("glitch_done", load_done, 1);
      chk("glitch_fall_t", fall_cyc, last_we_cyc + 1);
      for (int r = 0; r < 4; r++) begin
         junk = 8'($urandom_range(0, 255));
         if (junk == 8'h55) junk = 8'h56;
         send_byte(junk);
         idle($urandom_range(0, 5));
         n = $urandom_range(1, 20);
         words_q = {};
         for (int i = 0; i < n; i++) words_q.push_back($urandom);
         load(n, 1);
      end
      cmp_mem();
      exp_q.push_back({4'd0, 32'hCAFEF00D});
      model_mem[0] = 32'hCAFEF00D;
      send_byte(8'h55);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'hCA);
      send_byte(8'hFE);
      send_byte(8'hF0);
      send_byte(8'h0D);
      send_byte(8'h01);
      send_byte(8'h02);
      idle(2);
      chk("rst_mid_hold_pre", cpu_hold, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_hold", cpu_hold, 0);
      chk("rst_mid_we", imem_we, 0);
      chk("rst_mid_adrs", imem_adrs, 0);
      chk("rst_mid_wdata", imem_wdata, 0);
      chk("rst_mid_done", load_done, 0);
      reset = 1'b0;
      for (int i = 3; i < 9; i++) send_byte(8'(i));
      idle(20);
      chk("rst_mid_writes", exp_q.size(), 0);
      chk("rst_mid_hold_post", cpu_hold, 0);
      chk("rst_mid_done_post", load_done, 0);
      cmp_mem();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Serial program loader: the writer for the CPU's instruction memory, which the core only reads. It receives 8N1 UART bytes on a board pin, parses a small framed load command, and writes 32-bit instruction words into instruction RAM. While a load is in progress it holds the CPU in reset, so a new program is loaded without resynthesis. Sits beside the instruction memory in the top level, sharing the board clock and the debounced reset.

## Interface
- CLKS_PER_BIT, 434: board clocks per UART bit (50 MHz / 115200); legal range 4..65535.
- ADRS_W, 8: instruction memory word-address width.
- clk  input  1  board clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; one clock, no other clocks.
- rxd  input  1  asynchronous UART line, idle high.
- imem_we  output  1  one-cycle write strobe to instruction memory.
- imem_adrs  output  ADRS_W  word address of the write.
- imem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  high while loading; OR it into the CPU reset.
- load_done  output  1  high after a load completes; low otherwise.
- frame_err  output  1  sticky error flag.

## Operation
- rxd passes through a two-flop synchronizer (reset value 1) before any use.
- UART RX FSM states: IDLE, START, BITS, STOP.
  - IDLE: a synchronized low level moves to START and clears the bit counter.
  - START: re-samples at CLKS_PER_BIT/2 (integer division). If the sample is high it is a glitch and the FSM returns to IDLE. If it is low the FSM goes to BITS.
  - BITS: samples every CLKS_PER_BIT clocks, LSB first, 8 bits.
  - STOP: samples one bit later. A high sample gives a one-cycle byte_valid. A low sample gives a byte error, no byte_valid, and a return to IDLE.
- Loader FSM states: SYNC, CNT_HI, CNT_LO, DATA, DONE.
  - SYNC: waits for byte 0x55; all other bytes are ignored. Accepting 0x55 sets cpu_hold=1, clears load_done and frame_err, resets the address to 0, and moves to CNT_HI.
  - CNT_HI, CNT_LO: capture a 16-bit word count N, big-endian. If N=0 the FSM goes straight to DONE.
  - DATA: shifts bytes in MSB-first (big-endian). Every 4th byte produces a write at the current address, then the address increments and the remaining count decrements. After the Nth word the FSM goes to DONE.
  - DONE: cpu_hold=0 and load_done=1. A new 0x55 starts a fresh load, taking the same action as from SYNC.
- Address wraps modulo 2^ADRS_W. If N > 2^ADRS_W, the later words overwrite earlier ones and no error is raised.
- A byte error while in CNT_HI, CNT_LO or DATA sets frame_err=1, drops cpu_hold, discards the partial word, and returns the loader to SYNC. Words already written stay in memory.
- A byte error in SYNC or DONE is ignored and frame_err is unchanged.
- frame_err is cleared only by reset or by an accepted 0x55.

## Timing
- Reset values: imem_we=0, imem_adrs=0, imem_wdata=0, cpu_hold=0, load_done=0, frame_err=0. Both FSMs start in IDLE/SYNC.
- Reset mid-load aborts immediately. The next cycle shows the reset values and no write strobe.
- Synchronizer latency is 2 clocks.
- byte_valid is asserted in the cycle after the stop-bit sample.
- For the 4th byte of a word, with byte_valid in cycle T:
  - imem_we=1 in cycle T+1 only.
  - imem_adrs and imem_wdata are valid in T+1 and hold until the next write.
- cpu_hold rises in the cycle after byte_valid of 0x55.
- cpu_hold falls, and load_done rises, in the cycle after the final imem_we. For N=0 this happens in the cycle after byte_valid of CNT_LO.
- Back-to-back frames (a start bit right after the stop-bit sample) must be received without loss.
- RX returns to IDLE at the stop-bit midpoint.

## Test plan
- Bench uses CLKS_PER_BIT=4, ADRS_W=4.
- Reset, idle line -> all outputs 0 and no imem_we for 1000 clocks.
- Send 55 00 02 DE AD BE EF 12 34 56 78 -> two writes:
  - DEADBEEF@0, then 12345678@1.
  - cpu_hold goes high after 0x55 and low the cycle after the 2nd write.
  - load_done=1 at the end.
- Send 55 00 00 -> no writes; cpu_hold pulses high for the 2 count bytes, then load_done=1.
- Send 55 00 01 AA, then a frame with its stop bit driven low -> frame_err=1, cpu_hold=0, no write. A following 55 clears frame_err.
- Send 55 00 11, then 17 words whose value equals their index -> address wraps, so word 16 is written to adrs 0 with data 0x00000010.
- Additional checks:
  - A low glitch on rxd shorter than 2 clocks produces no byte.
  - Reset asserted mid-DATA drops cpu_hold the next cycle and produces no further writes.
